down_counter_4bit: RTL and testbench

DOWN_COUNTER_4BIT -- requirements
Module: down_counter_4bit

---
 rtl/down_counter_pkg.sv | 24 ++
 rtl/down_counter_4bit.sv | 104 ++++++++++
 tb/tb_down_counter_4bit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down counter: FSM state
// enumeration, default counter width and a small decode helper.
package down_counter_pkg;

   // Default counter width in bits.
   localparam int DEFAULT_WIDTH = 4;

   // Counter control states.
   //   IDLE : no period loaded (after reset or after a load of zero).
   //   RUN  : counting down; the only state in which busy is high.
   //   DONE : a one-shot count reached zero and is waiting for a new load.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // busy is a pure decode of the state, kept here so every user of the
   // enumeration agrees on its meaning.
   function automatic logic state_is_busy(input state_e s);
      return (s == RUN);
   endfunction

endpackage : down_counter_pkg

// File: rtl/down_counter_4bit.sv
// Loadable down counter with one-shot or auto-reload operation.
//
// A load copies load_val into both the live count and the reload
// register. While running, each enabled cycle decrements the count. The
// step that takes the count from 1 is the terminal step. It raises tc for
// one cycle and then either reloads the stored period (reload_en=1) or
// parks the count at zero in DONE (reload_en=0). Priority is
// rst > load > en in every state, so a load coinciding with a terminal
// step restarts the count and suppresses tc. The count never steps below
// one inside RUN, so it can never wrap.
module down_counter_4bit
   import down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             reload_en,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             busy
);

   // Value one at counter width, for the decrement and terminal compare.
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] reload_q;
   logic             tc_q;
   logic             busy_q;

   // Single FSM register block: state, count, reload period and the
   // registered tc/busy outputs all update together on the rising edge.
   // NOTE: non-blocking assignments throughout, so every register sees the
   // pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else if (load) begin
         // A load overrides counting in every state and never emits tc.
         count_q  <= load_val;
         reload_q <= load_val;
         tc_q     <= 1'b0;
         if (load_val != '0) begin
            state_q <= RUN;
            busy_q  <= state_is_busy(RUN);
         end else begin
            state_q <= IDLE;
            busy_q  <= state_is_busy(IDLE);
         end
      end else begin
         // tc is a single-cycle pulse; only the terminal step below sets it.
         tc_q <= 1'b0;
         unique case (state_q)
            RUN: begin
               if (en) begin
                  if (count_q > ONE) begin
                     count_q <= count_q - ONE;
                  end else if (count_q == ONE) begin
                     tc_q <= 1'b1;
                     if (reload_en) begin
                        count_q <= reload_q;
                     end else begin
                        count_q <= '0;
                        state_q <= DONE;
                        busy_q  <= state_is_busy(DONE);
                     end
                  end else begin
                     // Zero count inside RUN cannot be reached through a
                     // load; fall back to IDLE rather than wrapping.
                     state_q <= IDLE;
                     busy_q  <= state_is_busy(IDLE);
                  end
               end
            end
            IDLE, DONE: begin
               // Count holds and en is ignored until the next load.
            end
            default: begin
               // Unused encoding: recover to a clean idle state.
               state_q <= IDLE;
               count_q <= '0;
               busy_q  <= state_is_busy(IDLE);
            end
         endcase
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      out  = count_q;
      tc   = tc_q;
      busy = busy_q;
   end

endmodule : down_counter_4bit

// File: tb/tb_down_counter_4bit.sv
// Self-checking bench for down_counter_4bit: directed scenarios followed
// by randomized traffic, all compared against an integer-level model.
module tb_down_counter_4bit;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         en = 1'b0;
   logic         reload_en = 1'b0;
   logic [W-1:0] out;
   logic         tc;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state, expressed as plain integers.
   int m_remaining = 0;   // current count
   int m_period    = 0;   // stored period for auto-reload
   bit m_running   = 0;   // actively counting
   bit m_pulse     = 0;   // terminal event happened on the last edge

   down_counter_4bit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_val  (load_val),
      .en        (en),
      .reload_en (reload_en),
      .out       (out),
      .tc        (tc),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Behavioural rules of the counter applied to one clock edge.
   task automatic model_edge(input bit r, input bit l, input int lv,
                             input bit e, input bit re);
      m_pulse = 0;
      if (r) begin
         m_remaining = 0;
         m_period    = 0;
         m_running   = 0;
      end else if (l) begin
         m_remaining = lv;
         m_period    = lv;
         m_running   = (lv != 0);
      end else if (m_running && e) begin
         if (m_remaining > 1) begin
            m_remaining = m_remaining - 1;
         end else begin
            m_pulse = 1;
            if (re) begin
               m_remaining = m_period;
            end else begin
               m_remaining = 0;
               m_running   = 0;
            end
         end
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare all outputs.
   task automatic step(input string tag, input bit r, input bit l,
                       input int lv, input bit e, input bit re);
      @(negedge clk);
      rst       = r;
      load      = l;
      load_val  = W'(lv);
      en        = e;
      reload_en = re;
      @(posedge clk);
      #1;
      model_edge(r, l, lv, e, re);
      check({tag, ".out"},  int'(out),  m_remaining);
      check({tag, ".tc"},   int'(tc),   int'(m_pulse));
      check({tag, ".busy"}, int'(busy), int'(m_running));
   endtask

   initial begin
      int seq5[6] = '{5, 4, 3, 2, 1, 0};
      int seq3[9] = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
      int seqen[5] = '{4, 3, 3, 3, 2};
      bit en_pat[4] = '{1, 0, 0, 1};

      // Reset for two cycles, then enable without a load: stays at zero.
      step("rst0", 1, 0, 0, 0, 0);
      step("rst1", 1, 1, 7, 1, 0);
      check("rst.out_literal", int'(out), 0);
      for (int i = 0; i < 3; i++) step("idle_en", 0, 0, 0, 1, 0);

      // One-shot from 5 with en held.
      step("os_load", 0, 1, 5, 1, 0);
      check("os.seq", int'(out), seq5[0]);
      for (int i = 1; i < 6; i++) begin
         step("os_run", 0, 0, 0, 1, 0);
         check("os.seq", int'(out), seq5[i]);
         check("os.tc_literal", int'(tc), (i == 5) ? 1 : 0);
      end
      for (int i = 0; i < 3; i++) step("os_done", 0, 0, 0, 1, 0);
      check("os.hold_zero", int'(out), 0);

      // Auto-reload from 3: tc every third cycle, busy never drops.
      step("ar_load", 0, 1, 3, 1, 1);
      check("ar.seq", int'(out), seq3[0]);
      for (int i = 1; i < 9; i++) begin
         step("ar_run", 0, 0, 0, 1, 1);
         check("ar.seq", int'(out), seq3[i]);
         check("ar.busy_literal", int'(busy), 1);
      end

      // Enable gating: 4, then en 1,0,0,1 gives 3,3,3,2.
      step("eg_load", 0, 1, 4, 0, 0);
      check("eg.seq", int'(out), seqen[0]);
      for (int i = 0; i < 4; i++) begin
         step("eg_run", 0, 0, 0, en_pat[i], 0);
         check("eg.seq", int'(out), seqen[i+1]);
      end

      // Reload mid-count from out=2 to 9.
      step("ld_a", 0, 1, 2, 1, 0);
      step("ld9", 0, 1, 9, 1, 0);
      check("ld9.out", int'(out), 9);
      check("ld9.tc", int'(tc), 0);
      // Load 6 on what would be a terminal step (out=1, en=1, reload on).
      step("ld_b", 0, 1, 1, 1, 1);
      step("ld6", 0, 1, 6, 1, 1);
      check("ld6.out", int'(out), 6);
      check("ld6.tc", int'(tc), 0);
      // Load of zero returns to idle.
      step("ld0", 0, 1, 0, 1, 1);
      step("ld0_en", 0, 0, 0, 1, 1);

      // Reset while counting at 7, then enable without load.
      step("rr_load", 0, 1, 7, 0, 1);
      step("rr_rst", 1, 0, 0, 1, 1);
      check("rr.out", int'(out), 0);
      for (int i = 0; i < 3; i++) step("rr_en", 0, 0, 0, 1, 1);

      // Upper boundary: largest period auto-reloads through a full cycle.
      step("max_load", 0, 1, 15, 1, 1);
      for (int i = 0; i < 16; i++) step("max_run", 0, 0, 0, 1, 1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bit r  = ($urandom_range(39) == 0);
         bit l  = ($urandom_range(7) == 0);
         int lv = $urandom_range(15);
         bit e  = ($urandom_range(3) != 0);
         bit re = $urandom_range(1) != 0;
         step("rand", r, l, lv, e, re);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_down_counter_4bit
